// File: rtl/global_buffer_pkg.sv
// Global buffer shared definitions: tile-select width, stream-router channel
// mode encoding and the helper that resolves a channel's injection direction.
package global_buffer_pkg;

    localparam int TILE_SEL_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        STRM_MODE_PARITY = 2'b00,
        STRM_MODE_EAST   = 2'b01,
        STRM_MODE_WEST   = 2'b10,
        STRM_MODE_OFF    = 2'b11
    } strm_mode_e;

    // Parity mode sends even tiles east and odd tiles west; other modes pass through.
    function automatic strm_mode_e eff_dir(input strm_mode_e mode, input logic tile_odd);
        strm_mode_e dir;
        dir = mode;
        if (mode == STRM_MODE_PARITY) begin
            dir = tile_odd ? STRM_MODE_WEST : STRM_MODE_EAST;
        end
        return dir;
    endfunction

endpackage

// File: rtl/glb_strm_pipe.sv
// Fixed-latency register pipeline used on every neighbour-bound stream.
// DEPTH stages, all holding while clk_en is low, all cleared by async reset.
module glb_strm_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the stages forward by one on every enabled clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (clk_en) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/glb_core_strm_router_mc.sv
// Multi-channel stream router for one global-buffer tile. Each channel either
// injects local traffic eastward or westward (or is switched off) and delivers
// the opposite stream to the local switch. Chain ends are turned around by
// feeding the tile's own registered output back in, so no combinational loop.
// Optional per-channel delivery counters: define GLB_STRM_ROUTER_PERF_EN.
module glb_core_strm_router_mc
    import global_buffer_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int PKT_WIDTH  = 64,
    parameter int PIPE_DEPTH = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clk_en,
`ifdef GLB_STRM_ROUTER_PERF_EN
    input  logic                           perf_clr,
    output logic [NUM_CH*32-1:0]           perf_cnt,
`endif
    input  logic [TILE_SEL_ADDR_WIDTH-1:0] glb_tile_id,
    input  logic [NUM_CH-1:0]              w2e_wsti_vld,
    input  logic [NUM_CH*PKT_WIDTH-1:0]    w2e_wsti_data,
    input  logic [NUM_CH-1:0]              e2w_esti_vld,
    input  logic [NUM_CH*PKT_WIDTH-1:0]    e2w_esti_data,
    output logic [NUM_CH-1:0]              w2e_esto_vld,
    output logic [NUM_CH*PKT_WIDTH-1:0]    w2e_esto_data,
    output logic [NUM_CH-1:0]              e2w_wsto_vld,
    output logic [NUM_CH*PKT_WIDTH-1:0]    e2w_wsto_data,
    input  logic [NUM_CH-1:0]              sw2sr_vld,
    input  logic [NUM_CH*PKT_WIDTH-1:0]    sw2sr_data,
    output logic [NUM_CH-1:0]              sr2sw_vld,
    output logic [NUM_CH*PKT_WIDTH-1:0]    sr2sw_data,
    input  logic                           cfg_tile_connected_prev,
    input  logic                           cfg_tile_connected_next,
    input  logic [NUM_CH*2-1:0]            cfg_ch_mode
);

    // Packed packet: valid in the MSB, payload below it.
    localparam int PW = PKT_WIDTH + 1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PW-1:0] w_turn_w;
        logic [PW-1:0] w_turn_e;
        logic [PW-1:0] w_inj;
        logic [PW-1:0] w_esto_src;
        logic [PW-1:0] w_wsto_src;
        logic [PW-1:0] w_sr2sw;
        logic [PW-1:0] w_esto_q;
        logic [PW-1:0] w_wsto_q;
        strm_mode_e    w_dir;

        assign w_dir    = eff_dir(strm_mode_e'(cfg_ch_mode[2*g +: 2]), glb_tile_id[0]);
        assign w_inj    = {sw2sr_vld[g], sw2sr_data[g*PKT_WIDTH +: PKT_WIDTH]};
        // Unconnected side: loop our own registered output back as the input.
        assign w_turn_w = cfg_tile_connected_prev
                        ? {w2e_wsti_vld[g], w2e_wsti_data[g*PKT_WIDTH +: PKT_WIDTH]}
                        : w_wsto_q;
        assign w_turn_e = cfg_tile_connected_next
                        ? {e2w_esti_vld[g], e2w_esti_data[g*PKT_WIDTH +: PKT_WIDTH]}
                        : w_esto_q;

        // Select delivery and neighbour-bound sources; a disabled channel sends zeros.
        always_comb begin
            w_sr2sw    = '0;
            w_esto_src = '0;
            w_wsto_src = '0;
            case (w_dir)
                STRM_MODE_EAST: begin
                    w_sr2sw    = w_turn_w;
                    w_esto_src = w_inj;
                    w_wsto_src = w_turn_e;
                end
                STRM_MODE_WEST: begin
                    w_sr2sw    = w_turn_e;
                    w_wsto_src = w_inj;
                    w_esto_src = w_turn_w;
                end
                default: begin
                end
            endcase
        end

        glb_strm_pipe #(.WIDTH(PW), .DEPTH(PIPE_DEPTH)) u_esto_pipe (
            .clk    (clk),
            .reset  (reset),
            .clk_en (clk_en),
            .i_data (w_esto_src),
            .o_data (w_esto_q)
        );

        glb_strm_pipe #(.WIDTH(PW), .DEPTH(PIPE_DEPTH)) u_wsto_pipe (
            .clk    (clk),
            .reset  (reset),
            .clk_en (clk_en),
            .i_data (w_wsto_src),
            .o_data (w_wsto_q)
        );

        assign w2e_esto_vld[g]                        = w_esto_q[PW-1];
        assign w2e_esto_data[g*PKT_WIDTH +: PKT_WIDTH] = w_esto_q[PKT_WIDTH-1:0];
        assign e2w_wsto_vld[g]                        = w_wsto_q[PW-1];
        assign e2w_wsto_data[g*PKT_WIDTH +: PKT_WIDTH] = w_wsto_q[PKT_WIDTH-1:0];
        assign sr2sw_vld[g]                           = w_sr2sw[PW-1];
        assign sr2sw_data[g*PKT_WIDTH +: PKT_WIDTH]    = w_sr2sw[PKT_WIDTH-1:0];

`ifdef GLB_STRM_ROUTER_PERF_EN
        logic [31:0] r_perf_cnt;

        // Count local deliveries, saturating; clear wins over increment.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_perf_cnt <= '0;
            end else if (perf_clr) begin
                r_perf_cnt <= '0;
            end else if (clk_en && w_sr2sw[PW-1] && (r_perf_cnt != 32'hFFFF_FFFF)) begin
                r_perf_cnt <= r_perf_cnt + 32'd1;
            end
        end

        assign perf_cnt[g*32 +: 32] = r_perf_cnt;
`endif
    end

endmodule
